// File: rtl/corelet_pkg.sv
// corelet_pkg: types and default widths shared by the corelet datapath blocks.
//   sfu_state_t : special-function stage FSM states
//   COL         : default lanes per psum vector
//   PSUM_BW     : default bits per psum lane
package corelet_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RD,
        LAT,
        WR,
        DONE
    } sfu_state_t;

endpackage

// File: rtl/sfu_lane.sv
// sfu_lane: one lane of the special-function datapath.
//   vec     in  psum_bw  lane of the vector popped from the ofifo
//   mem_q   in  psum_bw  lane of the OP SRAM read data
//   sum     in  psum_bw  lane of the registered accumulated sum
//   use_sum in  1        write back sum instead of vec (any pass after the first)
//   relu_en in  1        clamp negative values to zero (final pass)
//   add_out out psum_bw  vec + mem_q, wrapping, no saturation
//   wr_out  out psum_bw  value to write back to the OP SRAM
module sfu_lane
    import corelet_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW
) (
    input  logic [psum_bw-1:0] vec,
    input  logic [psum_bw-1:0] mem_q,
    input  logic [psum_bw-1:0] sum,
    input  logic               use_sum,
    input  logic               relu_en,
    output logic [psum_bw-1:0] add_out,
    output logic [psum_bw-1:0] wr_out
);

    logic [psum_bw-1:0] src;

    assign add_out = vec + mem_q;
    assign src     = use_sum ? sum : vec;
    assign wr_out  = (relu_en && src[psum_bw-1]) ? '0 : src;

endmodule

// File: rtl/sfu_accum.sv
// sfu_accum: drains psum vectors from the ofifo and accumulates them lane-wise in the
// OP SRAM over n_kij kernel passes (read-modify-write), applying ReLU on the final pass.
//   clk, reset   clock, asynchronous active-high reset
//   start        begin a run (sampled only in IDLE)
//   busy, done   not-idle flag, one-cycle completion pulse
//   ofifo_*      ofifo head vector, valid flag and pop strobe
//   mem_*        single-port OP SRAM: q (read data), d, addr, cen/wen (active-low)
module sfu_accum
    import corelet_pkg::*;
#(
    parameter int unsigned col       = COL,
    parameter int unsigned psum_bw   = PSUM_BW,
    parameter int unsigned n_out     = 36,
    parameter int unsigned n_kij     = 9,
    parameter int unsigned addr_bw   = 9,
    parameter int unsigned base_addr = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_out,
    output logic                   ofifo_rd,
    input  logic [psum_bw*col-1:0] mem_q,
    output logic [psum_bw*col-1:0] mem_d,
    output logic [addr_bw-1:0]     mem_addr,
    output logic                   mem_cen,
    output logic                   mem_wen
);

    localparam int unsigned VEC_W = psum_bw * col;
    localparam int unsigned IDX_W = (n_out > 1) ? $clog2(n_out) : 1;
    localparam int unsigned KIJ_W = (n_kij > 1) ? $clog2(n_kij) : 1;

    sfu_state_t state, state_next;

    logic [IDX_W-1:0]   idx;
    logic [KIJ_W-1:0]   kij;
    logic [VEC_W-1:0]   vec_r;
    logic [VEC_W-1:0]   sum_r;
    logic [VEC_W-1:0]   add_v;
    logic [VEC_W-1:0]   wr_v;
    logic [addr_bw-1:0] addr;
    logic               first;
    logic               last;
    logic               idx_last;

    assign first    = (kij == '0);
    assign last     = (kij == KIJ_W'(n_kij - 1));
    assign idx_last = (idx == IDX_W'(n_out - 1));
    assign addr     = addr_bw'(base_addr) + addr_bw'(idx);

    for (genvar i = 0; i < col; i++) begin : g_lane
        sfu_lane #(
            .psum_bw (psum_bw)
        ) u_lane (
            .vec     (vec_r[psum_bw*i +: psum_bw]),
            .mem_q   (mem_q[psum_bw*i +: psum_bw]),
            .sum     (sum_r[psum_bw*i +: psum_bw]),
            .use_sum (!first),
            .relu_en (last),
            .add_out (add_v[psum_bw*i +: psum_bw]),
            .wr_out  (wr_v[psum_bw*i +: psum_bw])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            kij   <= '0;
            vec_r <= '0;
            sum_r <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
                        kij <= '0;
                    end
                end
                FETCH: begin
                    if (ofifo_valid) vec_r <= ofifo_out;
                end
                LAT: sum_r <= add_v;
                WR: begin
                    if (idx_last) begin
                        idx <= '0;
                        // kij stays at the last pass so done sees a stable counter
                        if (!last) kij <= kij + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        ofifo_rd   = 1'b0;
        mem_cen    = 1'b1;
        mem_wen    = 1'b1;
        mem_addr   = '0;
        mem_d      = '0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                ofifo_rd = ofifo_valid;
                // the first pass writes raw data, so it skips the read
                if (ofifo_valid) state_next = first ? WR : RD;
            end
            RD: begin
                mem_cen    = 1'b0;
                mem_addr   = addr;
                state_next = LAT;
            end
            LAT: state_next = WR;
            WR: begin
                mem_cen    = 1'b0;
                mem_wen    = 1'b0;
                mem_addr   = addr;
                mem_d      = wr_v;
                state_next = (idx_last && last) ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sfu_accum.sv
// tb_sfu_accum: randomized scoreboard bench for sfu_accum with an OP SRAM model.
module tb_sfu_accum;

    localparam int unsigned VW = 128;

    typedef struct {
        logic [8:0]    addr;
        logic [VW-1:0] data;
    } wr_t;

    typedef struct {
        logic [VW-1:0] vec;
        wr_t           wr;
    } item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, ofifo_valid, ofifo_rd, mem_cen, mem_wen;
    logic [VW-1:0] ofifo_out, mem_q, mem_d;
    logic [8:0]    mem_addr;

    logic          s_start, s_busy, s_done, s_valid, s_rd, s_cen, s_wen;
    logic [VW-1:0] s_out, s_d;
    logic [VW-1:0] s_q = '0;
    logic [8:0]    s_addr;

    logic [VW-1:0] sram [0:511];
    logic [VW-1:0] fin  [36];
    item_t         src_q [$];
    wr_t           exp_q [$];
    int            n_chk = 0;
    int            n_bad = 0;
    int            pc = 0;
    int            pops = 0;
    bit            stall_mode = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) pc++;

    sfu_accum u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .ofifo_valid (ofifo_valid),
        .ofifo_out   (ofifo_out),
        .ofifo_rd    (ofifo_rd),
        .mem_q       (mem_q),
        .mem_d       (mem_d),
        .mem_addr    (mem_addr),
        .mem_cen     (mem_cen),
        .mem_wen     (mem_wen)
    );

    sfu_accum #(
        .n_out (4),
        .n_kij (1)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .start       (s_start),
        .busy        (s_busy),
        .done        (s_done),
        .ofifo_valid (s_valid),
        .ofifo_out   (s_out),
        .ofifo_rd    (s_rd),
        .mem_q       (s_q),
        .mem_d       (s_d),
        .mem_addr    (s_addr),
        .mem_cen     (s_cen),
        .mem_wen     (s_wen)
    );

    // Single-port SRAM, one-cycle read latency
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram[mem_addr] <= mem_d;
            else          mem_q <= sram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int l = 0; l < 8; l++) if (v[16*l+15]) r[16*l +: 16] = 16'd0;
        return r;
    endfunction

    // Reference model: running lane sums per output pixel, written every pass
    task automatic build(input int mode);
        logic [15:0] acc [36][8];
        logic [15:0] v, w;
        item_t       it;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 36; i++) begin
                for (int l = 0; l < 8; l++) begin
                    case (mode)
                        0:       v = 16'd1;
                        1:       v = (l == 0) ? -16'sd5 : (l == 1) ? 16'd3 : 16'($urandom);
                        2:       v = (k == 0) ? 16'h7FFF : (k == 8) ? 16'd1 : 16'd0;
                        default: v = 16'($urandom);
                    endcase
                    acc[i][l] = (k == 0) ? v : acc[i][l] + v;
                    w = (k == 8 && acc[i][l][15]) ? 16'd0 : acc[i][l];
                    it.vec[16*l +: 16]     = v;
                    it.wr.data[16*l +: 16] = w;
                end
                it.wr.addr = 9'(i);
                src_q.push_back(it);
                if (k == 8) fin[i] = it.wr.data;
            end
        end
    endtask

    // ofifo model: pops on ofifo_rd, hands the expected write to the scoreboard
    initial begin
        bit    will_pop;
        item_t it;
        ofifo_valid = 1'b0;
        ofifo_out   = '0;
        forever begin
            @(negedge clk);
            will_pop = ofifo_rd;
            if (ofifo_rd) chk("rd_without_valid", VW'(ofifo_valid), VW'(1));
            @(posedge clk);
            #1;
            if (will_pop && src_q.size() > 0) begin
                it = src_q.pop_front();
                exp_q.push_back(it.wr);
                pops++;
            end
            ofifo_valid = (src_q.size() > 0) && (!stall_mode || ((pc / 3) % 2 == 0));
            ofifo_out   = (src_q.size() > 0) ? src_q[0].vec : '0;
        end
    end

    // Write monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset && !mem_cen && !mem_wen) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d, required no write", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", VW'(mem_addr), VW'(e.addr));
                    chk("wr_data", mem_d, e.data);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_busy", VW'(busy), '0);
        chk("rst_done", VW'(done), '0);
        chk("rst_ofifo_rd", VW'(ofifo_rd), '0);
        chk("rst_mem_cen", VW'(mem_cen), VW'(1));
        chk("rst_mem_wen", VW'(mem_wen), VW'(1));
        chk("rst_mem_addr", VW'(mem_addr), '0);
        chk("rst_mem_d", mem_d, '0);
    endtask

    task automatic run_main(input int mode, input bit stall, input int rst_after);
        int t0, guard;
        build(mode);
        stall_mode = stall;
        pops = 0;
        @(negedge clk);
        start = 1'b1;
        t0 = pc;
        @(negedge clk);
        start = 1'b0;
        if (rst_after > 0) begin
            guard = 0;
            while (pops < rst_after && guard < 5000) begin
                @(posedge clk);
                #2;
                guard++;
            end
            chk("pops_before_reset", VW'(pops), VW'(rst_after));
            reset = 1'b1;
            #1;
            check_reset_outputs();
            src_q.delete();
            exp_q.delete();
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        guard = 0;
        while (done !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", VW'(done), VW'(1));
        if (!stall) chk("done_cycle", VW'(pc - t0), VW'(1225));
        @(negedge clk);
        chk("done_one_cycle", VW'(done), '0);
        chk("idle_after_done", VW'(busy), '0);
        chk("writes_outstanding", VW'(exp_q.size()), '0);
        chk("pops_total", VW'(pops), VW'(324));
        for (int i = 0; i < 36; i++) chk($sformatf("final_mem[%0d]", i), sram[i], fin[i]);
    endtask

    task automatic run_small();
        logic [VW-1:0] svec [4];
        int            nwr, last_wr, done_pc, spops, guard;
        bit            will;
        for (int i = 0; i < 4; i++) svec[i] = {$urandom, $urandom, $urandom, $urandom};
        nwr = 0; last_wr = -100; done_pc = -1; spops = 0; guard = 0;
        s_valid = 1'b1;
        s_out = svec[0];
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        while (done_pc < 0 && guard < 100) begin
            if (!s_cen && s_wen) chk("small_read_issued", VW'(s_addr), '1);
            if (!s_cen && !s_wen) begin
                chk("small_wr_addr", VW'(s_addr), VW'(nwr));
                chk("small_wr_data", s_d, relu_vec(svec[nwr < 4 ? nwr : 3]));
                nwr++;
                last_wr = pc;
            end
            if (s_done) done_pc = pc;
            will = s_rd;
            @(posedge clk);
            #1;
            if (will) begin
                spops++;
                s_out = svec[spops < 4 ? spops : 3];
            end
            @(negedge clk);
            guard++;
        end
        chk("small_writes", VW'(nwr), VW'(4));
        chk("small_done_after_wr", VW'(done_pc - last_wr), VW'(1));
        chk("small_pops", VW'(spops), VW'(4));
        s_valid = 1'b0;
        @(negedge clk);
        chk("small_idle", VW'(s_busy), '0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        s_valid = 1'b0;
        s_out = '0;
        #3;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_main(0, 1'b0, 0);
        run_main(1, 1'b0, 0);
        run_main(2, 1'b0, 0);
        run_main(0, 1'b1, 0);
        run_main(3, 1'b0, 0);
        run_main(3, 1'b0, 100);
        run_main(0, 1'b0, 0);
        run_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
